// File: rtl/spwm_cordic_sequencer.sv
// spwm_cordic_sequencer
// Shares one pipelined CORDIC sine unit between three SPWM phases (0, 120 and
// 240 degrees). A sample-rate divider or sync_in requests a frame; the FSM
// issues three angles back-to-back, a tag pipeline routes each returned sine
// to its phase, and all three samples are published together.
// Optional feature macro: SPWM_AMP_SCALE_EN scales published samples by
// mod_index (unsigned Q0.8).
module spwm_cordic_sequencer #(
    parameter int SINE_W     = 10,
    parameter int CORDIC_LAT = 10,
    parameter int SAMPLE_DIV = 100
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              enable,
    input  logic              sync_in,
    input  logic [19:0]       freq_word,
    input  logic [7:0]        mod_index,
    input  logic              clear_overrun,
    output logic [19:0]       cordic_angle,
    input  logic [SINE_W-1:0] cordic_sine,
    output logic [SINE_W-1:0] sine_a,
    output logic [SINE_W-1:0] sine_b,
    output logic [SINE_W-1:0] sine_c,
    output logic              frame_valid,
    output logic              busy,
    output logic              overrun
);

    localparam int          DIV_W = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
    localparam logic [19:0] OFS_B = 20'h55555;
    localparam logic [19:0] OFS_C = 20'hAAAAB;

    typedef enum logic [2:0] {IDLE, ISSUE_A, ISSUE_B, ISSUE_C, DRAIN} state_t;
    typedef enum logic [1:0] {TAG_NONE, TAG_A, TAG_B, TAG_C} tag_t;

    state_t            state, state_next;
    logic [DIV_W-1:0]  div_cnt;
    logic              div_tick;
    logic              request;
    logic              accept;
    logic              drop;
    logic              publish;
    logic              load_b;
    logic              load_c;
    logic [19:0]       phase_acc;
    logic [19:0]       phase_next;
    logic [19:0]       frame_base;
    logic [SINE_W-1:0] shadow_a;
    logic [SINE_W-1:0] shadow_b;

    // tag_pipe[k] belongs to the value at CORDIC stage k: stage 0 is
    // cordic_angle, stage CORDIC_LAT is cordic_sine, so the last stage
    // names the phase whose sine is on the input this cycle.
    tag_t tag_pipe [0:CORDIC_LAT];

`ifdef SPWM_AMP_SCALE_EN
    function automatic logic [SINE_W-1:0] amp_scale(input logic [SINE_W-1:0] s,
                                                     input logic [7:0]        m);
        logic signed [SINE_W+8:0] prod;
        prod = (SINE_W+9)'($signed(s)) * (SINE_W+9)'($signed({1'b0, m}));
        return SINE_W'(prod >>> 8);
    endfunction
`else
    logic unused_mod_index;
    assign unused_mod_index = ^mod_index;
`endif

    assign div_tick   = enable && (div_cnt == DIV_W'(SAMPLE_DIV - 1));
    assign request    = enable && (sync_in || div_tick);
    assign publish    = (tag_pipe[CORDIC_LAT] == TAG_C);
    assign phase_next = phase_acc + freq_word;
    assign drop       = request && !accept;
    assign busy       = (state != IDLE);

    // FSM state register
    always_ff @(posedge clock) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_next;
    end

    // Next-state logic and per-state issue strobes
    always_comb begin
        state_next = state;
        accept     = 1'b0;
        load_b     = 1'b0;
        load_c     = 1'b0;
        case (state)
            IDLE: begin
                if (request) begin
                    accept     = 1'b1;
                    state_next = ISSUE_A;
                end
            end
            ISSUE_A: begin
                load_b     = 1'b1;
                state_next = ISSUE_B;
            end
            ISSUE_B: begin
                load_c     = 1'b1;
                state_next = ISSUE_C;
            end
            ISSUE_C: state_next = DRAIN;
            DRAIN: begin
                // A request landing on the publish cycle starts the next frame.
                if (publish) begin
                    if (request) begin
                        accept     = 1'b1;
                        state_next = ISSUE_A;
                    end else begin
                        state_next = IDLE;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Divider, phase accumulator, angle issue, tag routing, publish and overrun
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            div_cnt      <= '0;
            phase_acc    <= '0;
            frame_base   <= '0;
            cordic_angle <= '0;
            shadow_a     <= '0;
            shadow_b     <= '0;
            sine_a       <= '0;
            sine_b       <= '0;
            sine_c       <= '0;
            frame_valid  <= 1'b0;
            overrun      <= 1'b0;
            for (int unsigned i = 0; i <= CORDIC_LAT; i++) tag_pipe[i] <= TAG_NONE;
        end else begin
            if (!enable || request) div_cnt <= '0;
            else                    div_cnt <= div_cnt + DIV_W'(1);

            if (request) phase_acc <= phase_next;

            // frame_base keeps B/C angles tied to this frame even if a
            // dropped request advances phase_acc mid-issue.
            if (accept) begin
                frame_base   <= phase_next;
                cordic_angle <= phase_next;
            end else if (load_b) begin
                cordic_angle <= frame_base + OFS_B;
            end else if (load_c) begin
                cordic_angle <= frame_base + OFS_C;
            end

            tag_pipe[0] <= accept ? TAG_A : load_b ? TAG_B : load_c ? TAG_C : TAG_NONE;
            for (int unsigned i = 1; i <= CORDIC_LAT; i++) tag_pipe[i] <= tag_pipe[i-1];

            if (tag_pipe[CORDIC_LAT] == TAG_A) shadow_a <= cordic_sine;
            if (tag_pipe[CORDIC_LAT] == TAG_B) shadow_b <= cordic_sine;

            frame_valid <= publish;
            if (publish) begin
`ifdef SPWM_AMP_SCALE_EN
                sine_a <= amp_scale(shadow_a, mod_index);
                sine_b <= amp_scale(shadow_b, mod_index);
                sine_c <= amp_scale(cordic_sine, mod_index);
`else
                sine_a <= shadow_a;
                sine_b <= shadow_b;
                sine_c <= cordic_sine;
`endif
            end

            if (drop)               overrun <= 1'b1;
            else if (clear_overrun) overrun <= 1'b0;
        end
    end

endmodule

// File: tb/tb_spwm_cordic_sequencer.sv
// Testbench for spwm_cordic_sequencer: table-driven issue/wrap vectors,
// hand-written reset/overrun/enable/scaling sequences, and a randomized run
// against an event-scheduled reference model. The bench also plays the
// CORDIC: it returns a deterministic function of each angle CORDIC_LAT edges
// later, so expected samples follow from expected angles.
module tb_spwm_cordic_sequencer;

    localparam int SINE_W = 10;
    localparam int LAT    = 10;
    localparam int DIV    = 100;

    logic              clock = 1'b0;
    logic              reset_n = 1'b0;
    logic              enable = 1'b0;
    logic              sync_in = 1'b0;
    logic [19:0]       freq_word = '0;
    logic [7:0]        mod_index = '0;
    logic              clear_overrun = 1'b0;
    logic [19:0]       cordic_angle;
    logic [SINE_W-1:0] cordic_sine = '0;
    logic [SINE_W-1:0] sine_a, sine_b, sine_c;
    logic              frame_valid, busy, overrun;

    always #5 clock = ~clock;

    spwm_cordic_sequencer #(
        .SINE_W    (SINE_W),
        .CORDIC_LAT(LAT),
        .SAMPLE_DIV(DIV)
    ) dut (
        .clock        (clock),
        .reset_n      (reset_n),
        .enable       (enable),
        .sync_in      (sync_in),
        .freq_word    (freq_word),
        .mod_index    (mod_index),
        .clear_overrun(clear_overrun),
        .cordic_angle (cordic_angle),
        .cordic_sine  (cordic_sine),
        .sine_a       (sine_a),
        .sine_b       (sine_b),
        .sine_c       (sine_c),
        .frame_valid  (frame_valid),
        .busy         (busy),
        .overrun      (overrun)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [SINE_W-1:0] sine_of(input logic [19:0] a);
        return SINE_W'(a[19:10] ^ {a[4:0], a[9:5]});
    endfunction

    function automatic logic [SINE_W-1:0] exp_pub(input logic [SINE_W-1:0] s, input logic [7:0] m);
`ifdef SPWM_AMP_SCALE_EN
        int p;
        p = int'($signed(s)) * int'(m);
        return SINE_W'(p >>> 8);
`else
        return s;
`endif
    endfunction

    // CORDIC stand-in: sine after edge n is the function of the angle after edge n-LAT
    logic [19:0]       hist [0:LAT];
    bit                force_en = 1'b0;
    logic [SINE_W-1:0] force_val = '0;
    initial begin
        for (int k = 0; k <= LAT; k++) hist[k] = '0;
        forever begin
            @(negedge clock);
            for (int k = LAT; k > 0; k--) hist[k] = hist[k-1];
            hist[0] = cordic_angle;
            cordic_sine = force_en ? force_val : sine_of(hist[LAT]);
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clock);
        @(negedge clock);
    endtask

    task automatic do_reset();
        reset_n = 1'b0; enable = 1'b0; sync_in = 1'b0; clear_overrun = 1'b0;
        tick(); tick();
        reset_n = 1'b1;
    endtask

    // Reference model: frames as scheduled events (issue edge, publish edge)
    int          m_edge, m_div, m_pub, m_iss;
    logic [19:0] m_phase, m_angle;
    logic [19:0] m_fa [3];
    logic [SINE_W-1:0] m_sa, m_sb, m_sc;
    bit          m_ovr, m_fv;

    task automatic model_reset();
        m_edge = 0; m_div = 0; m_pub = -1; m_iss = -1;
        m_phase = '0; m_angle = '0; m_sa = '0; m_sb = '0; m_sc = '0;
        m_ovr = 1'b0; m_fv = 1'b0;
        for (int k = 0; k < 3; k++) m_fa[k] = '0;
    endtask

    task automatic model_step(input bit en, input bit sy, input bit clr,
                              input logic [19:0] fw, input logic [7:0] mi);
        int ne;
        bit req, drp;
        ne  = m_edge + 1;
        req = en && (sy || m_div == DIV - 1);
        m_div = (!en || req) ? 0 : m_div + 1;
        m_fv = 1'b0;
        drp  = 1'b0;
        if (m_pub == ne) begin
            m_sa = exp_pub(sine_of(m_fa[0]), mi);
            m_sb = exp_pub(sine_of(m_fa[1]), mi);
            m_sc = exp_pub(sine_of(m_fa[2]), mi);
            m_fv = 1'b1;
            m_pub = -1;
        end
        if (req) begin
            m_phase = m_phase + fw;
            if (m_pub == -1) begin
                m_fa[0] = m_phase;
                m_fa[1] = m_phase + 20'h55555;
                m_fa[2] = m_phase + 20'hAAAAB;
                m_iss = ne;
                m_pub = ne + LAT + 3;
            end else begin
                drp = 1'b1;
            end
        end
        if (drp)      m_ovr = 1'b1;
        else if (clr) m_ovr = 1'b0;
        if (m_iss >= 0 && ne - m_iss >= 0 && ne - m_iss <= 2) m_angle = m_fa[ne - m_iss];
        m_edge = ne;
    endtask

    typedef struct {
        bit          rst;
        logic [19:0] fw;
        logic [19:0] ea;
        logic [19:0] eb;
        logic [19:0] ec;
    } vec_t;

    vec_t tbl [4];

    initial begin
        logic [SINE_W-1:0] e1, e2, e3;
        logic [19:0] held;
        int first_req, first_fv, changes;

        tbl[0] = '{1'b1, 20'h04000, 20'h04000, 20'h59555, 20'hAEAAB};
        tbl[1] = '{1'b1, 20'hFFF00, 20'hFFF00, 20'h55455, 20'hAA9AB};
        tbl[2] = '{1'b0, 20'h00200, 20'h00100, 20'h55655, 20'hAABAB};
        tbl[3] = '{1'b0, 20'h80000, 20'h80100, 20'hD5655, 20'h2ABAB};

        // Reset values
        do_reset();
        chk("rst_angle", 32'(cordic_angle), 32'h0);
        chk("rst_sine_a", 32'(sine_a), 32'h0);
        chk("rst_sine_b", 32'(sine_b), 32'h0);
        chk("rst_sine_c", 32'(sine_c), 32'h0);
        chk("rst_fv", 32'(frame_valid), 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_ovr", 32'(overrun), 32'h0);

        // Table: issue order, phase wrap, frame_valid latency, routing
        for (int i = 0; i < 4; i++) begin
            if (tbl[i].rst) do_reset();
            enable = 1'b1; mod_index = 8'd255;
            freq_word = tbl[i].fw;
            sync_in = 1'b1;
            tick();
            sync_in = 1'b0;
            chk("tbl_angle_a", 32'(cordic_angle), 32'(tbl[i].ea));
            chk("tbl_busy", 32'(busy), 32'h1);
            tick();
            chk("tbl_angle_b", 32'(cordic_angle), 32'(tbl[i].eb));
            tick();
            chk("tbl_angle_c", 32'(cordic_angle), 32'(tbl[i].ec));
            tick();
            chk("tbl_angle_hold", 32'(cordic_angle), 32'(tbl[i].ec));
            for (int k = 4; k <= LAT + 3; k++) begin
                tick();
                chk("tbl_fv", 32'(frame_valid), (k == LAT + 3) ? 32'h1 : 32'h0);
            end
            chk("tbl_sine_a", 32'(sine_a), 32'(exp_pub(sine_of(tbl[i].ea), 8'd255)));
            chk("tbl_sine_b", 32'(sine_b), 32'(exp_pub(sine_of(tbl[i].eb), 8'd255)));
            chk("tbl_sine_c", 32'(sine_c), 32'(exp_pub(sine_of(tbl[i].ec), 8'd255)));
            chk("tbl_busy_end", 32'(busy), 32'h0);
            tick();
            chk("tbl_fv_pulse", 32'(frame_valid), 32'h0);
        end

        // Reset mid-frame: in-flight frame discarded, divider restarts
        do_reset();
        enable = 1'b1; freq_word = 20'h12345;
        sync_in = 1'b1; tick(); sync_in = 1'b0;
        tick(); tick(); tick(); tick();
        reset_n = 1'b0; tick(); tick(); tick();
        reset_n = 1'b1;
        first_req = -1; first_fv = -1;
        for (int j = 1; j <= DIV + LAT + 6; j++) begin
            tick();
            if (j == 1) begin
                chk("midrst_sine_a", 32'(sine_a), 32'h0);
                chk("midrst_busy", 32'(busy), 32'h0);
            end
            if (first_req < 0 && cordic_angle != 20'h0) first_req = j;
            if (first_fv < 0 && frame_valid) first_fv = j;
            if (j == DIV) chk("midrst_angle", 32'(cordic_angle), 32'h12345);
        end
        chk("midrst_first_tick", 32'(first_req), 32'(DIV));
        chk("midrst_first_fv", 32'(first_fv), 32'(DIV + LAT + 3));

        // Overrun: drop at tick+2, frame still publishes, phase advanced twice
        do_reset();
        enable = 1'b1; freq_word = 20'h01000; mod_index = 8'd255;
        sync_in = 1'b1; tick(); sync_in = 1'b0;
        tick();
        sync_in = 1'b1; tick(); sync_in = 1'b0;
        chk("ovr_set", 32'(overrun), 32'h1);
        chk("ovr_angle_c", 32'(cordic_angle), 32'hABAAB);
        for (int k = 3; k <= LAT + 3; k++) begin
            tick();
            chk("ovr_fv", 32'(frame_valid), (k == LAT + 3) ? 32'h1 : 32'h0);
        end
        chk("ovr_sine_a", 32'(sine_a), 32'(exp_pub(sine_of(20'h01000), 8'd255)));
        chk("ovr_sine_b", 32'(sine_b), 32'(exp_pub(sine_of(20'h56555), 8'd255)));
        chk("ovr_sine_c", 32'(sine_c), 32'(exp_pub(sine_of(20'hABAAB), 8'd255)));
        sync_in = 1'b1; tick(); sync_in = 1'b0;
        chk("ovr_phase_twice", 32'(cordic_angle), 32'h03000);
        tick();
        sync_in = 1'b1; clear_overrun = 1'b1; tick(); sync_in = 1'b0;
        chk("ovr_set_wins", 32'(overrun), 32'h1);
        tick(); clear_overrun = 1'b0;
        chk("ovr_clear", 32'(overrun), 32'h0);

        // Enable dropped during ISSUE_B: frame completes, then no activity
        do_reset();
        enable = 1'b1; freq_word = 20'h00800;
        sync_in = 1'b1; tick(); sync_in = 1'b0;
        tick();
        enable = 1'b0;
        for (int k = 2; k <= LAT + 3; k++) begin
            tick();
            chk("en_fv", 32'(frame_valid), (k == LAT + 3) ? 32'h1 : 32'h0);
        end
        held = cordic_angle;
        chk("en_angle_c", 32'(held), 32'hAB2AB);
        changes = 0;
        for (int k = 0; k < DIV + 10; k++) begin
            sync_in = (k % 7 == 0);
            tick();
            if (frame_valid || busy || cordic_angle != held) changes++;
        end
        sync_in = 1'b0;
        chk("en_idle_activity", 32'(changes), 32'h0);
        enable = 1'b1; sync_in = 1'b1; tick(); sync_in = 1'b0;
        chk("en_resume_angle", 32'(cordic_angle), 32'h01000);
        for (int k = 1; k <= LAT + 3; k++) tick();

        // Amplitude scaling corner values (raw samples when feature is off)
`ifdef SPWM_AMP_SCALE_EN
        e1 = SINE_W'(-200); e2 = SINE_W'(299); e3 = SINE_W'(0);
`else
        e1 = SINE_W'(-400); e2 = SINE_W'(301); e3 = SINE_W'(-512);
`endif
        for (int c = 0; c < 3; c++) begin
            do_reset();
            enable = 1'b1; force_en = 1'b1;
            force_val = (c == 0) ? SINE_W'(-400) : (c == 1) ? SINE_W'(301) : SINE_W'(-512);
            mod_index = (c == 0) ? 8'd128 : (c == 1) ? 8'd255 : 8'd0;
            tick();
            sync_in = 1'b1; tick(); sync_in = 1'b0;
            for (int k = 1; k <= LAT + 3; k++) tick();
            chk("scale_fv", 32'(frame_valid), 32'h1);
            chk("scale_a", 32'(sine_a), 32'((c == 0) ? e1 : (c == 1) ? e2 : e3));
            chk("scale_c", 32'(sine_c), 32'((c == 0) ? e1 : (c == 1) ? e2 : e3));
        end
        force_en = 1'b0;

        // Randomized run against the reference model
        do_reset();
        model_reset();
        enable = 1'b1;
        for (int c = 0; c < 4000; c++) begin
            if ($urandom_range(0, 199) == 0) enable = ~enable;
            sync_in       = (c < 2000) ? ($urandom_range(0, 149) == 0) : ($urandom_range(0, 24) == 0);
            clear_overrun = ($urandom_range(0, 29) == 0);
            freq_word     = 20'($urandom);
            mod_index     = 8'($urandom);
            model_step(enable, sync_in, clear_overrun, freq_word, mod_index);
            tick();
            chk("rnd_fv", 32'(frame_valid), 32'(m_fv));
            chk("rnd_busy", 32'(busy), (m_pub != -1) ? 32'h1 : 32'h0);
            chk("rnd_ovr", 32'(overrun), 32'(m_ovr));
            chk("rnd_angle", 32'(cordic_angle), 32'(m_angle));
            chk("rnd_sine_a", 32'(sine_a), 32'(m_sa));
            chk("rnd_sine_b", 32'(sine_b), 32'(m_sb));
            chk("rnd_sine_c", 32'(sine_c), 32'(m_sc));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
